// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matmul_pkg
// Purpose  : Shared types for the systolic matrix-multiplier input path.
// Revision : 1.0
// ============================================================================
package matmul_pkg;

    localparam int LANE_WIDTH = 8;

    typedef logic [LANE_WIDTH-1:0] lane_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CLEAR  = 3'd2,
        STREAM = 3'd3,
        FLUSH  = 3'd4,
        DONE   = 3'd5
    } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/feeder_tile_buffer.sv
`default_nettype none
// ============================================================================
// Module   : feeder_tile_buffer
// Purpose  : N*N element tile store, one write port, N parallel column reads.
// Revision : 1.0
// ============================================================================
module feeder_tile_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int ADDR_W     = $clog2(N*N),
    parameter int COL_W      = $clog2(N+1)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [COL_W-1:0]        rd_col,
    output logic [N*DATA_WIDTH-1:0] rd_lanes
);

    // No reset: tile contents survive both completion and reset.
    logic [DATA_WIDTH-1:0] mem [N*N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A column index of N reads as all zeros, which feeds the drain phase.
    for (genvar r = 0; r < N; r++) begin : g_lane
        logic [ADDR_W-1:0] rd_addr;
        assign rd_addr = ADDR_W'(r*N) + ADDR_W'(rd_col);
        assign rd_lanes[r*DATA_WIDTH +: DATA_WIDTH] =
            (int'(rd_col) < N) ? mem[rd_addr] : '0;
    end

endmodule
`default_nettype wire

// File: rtl/operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : operand_feeder
// Purpose  : Loads an N x N tile, then streams it column-wise into the skew
//            registers followed by zero padding.
// Revision : 1.0
// ============================================================================
module operand_feeder
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int FLUSH_CYCLES = 2*N-1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    hold,
    output logic [N*DATA_WIDTH-1:0] lane_data,
    output logic                    shift_o,
    output logic                    sync_clr_n_o,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W  = $clog2(N*N+1);
    localparam int K_W    = $clog2(N+1);
    localparam int F_W    = $clog2(FLUSH_CYCLES+1);
    localparam int ADDR_W = $clog2(N*N);

    feeder_state_e state, state_nxt;

    logic [IDX_W-1:0]        idx;
    logic [K_W-1:0]          k;
    logic [F_W-1:0]          fcnt;
    logic                    accept;
    logic                    last_elem;
    logic                    last_col;
    logic                    last_flush;
    logic [K_W-1:0]          rd_col;
    logic [N*DATA_WIDTH-1:0] col_lanes;

    assign accept     = in_valid && in_ready;
    assign last_elem  = (idx  == IDX_W'(N*N-1));
    assign last_col   = (k    == K_W'(N-1));
    assign last_flush = (fcnt == F_W'(FLUSH_CYCLES-1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        shift_o      = 1'b0;
        sync_clr_n_o = 1'b1;
        busy         = (state != IDLE);
        done         = 1'b0;
        unique case (state)
            IDLE:   if (start) state_nxt = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (accept && last_elem) state_nxt = CLEAR;
            end
            CLEAR: begin
                sync_clr_n_o = 1'b0;
                state_nxt    = STREAM;
            end
            STREAM: begin
                shift_o = !hold;
                if (!hold && last_col) state_nxt = FLUSH;
            end
            FLUSH: begin
                shift_o = !hold;
                if (!hold && last_flush) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx  <= '0;
            k    <= '0;
            fcnt <= '0;
        end else begin
            unique case (state)
                IDLE:   if (start) idx <= '0;
                LOAD:   if (accept) idx <= idx + IDX_W'(1);
                CLEAR:  k <= '0;
                STREAM: begin
                    if (!hold) begin
                        k <= k + K_W'(1);
                        if (last_col) fcnt <= '0;
                    end
                end
                FLUSH:  if (!hold) fcnt <= fcnt + F_W'(1);
                default: ;
            endcase
        end
    end

    // Lanes are registered, so prefetch column k+1 (column 0 while in CLEAR);
    // the shift out of the last column fetches index N, i.e. zeros.
    assign rd_col = (state == CLEAR) ? '0 : k + K_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_data <= '0;
        end else if (state == CLEAR || (state == STREAM && !hold)) begin
            lane_data <= col_lanes;
        end
    end

    feeder_tile_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .ADDR_W     (ADDR_W),
        .COL_W      (K_W)
    ) u_buffer (
        .clk      (clk),
        .wr_en    (accept),
        .wr_addr  (idx[ADDR_W-1:0]),
        .wr_data  (in_data),
        .rd_col   (rd_col),
        .rd_lanes (col_lanes)
    );

endmodule
`default_nettype wire

// File: tb/tb_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_feeder
// Purpose  : Randomized self-checking bench for operand_feeder against a
//            phase-level reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_operand_feeder;
    import matmul_pkg::*;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int FL = 2*N-1;
    localparam int NE = N*N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n, start, in_valid, hold;
    logic [DW-1:0]   in_data;
    logic            in_ready, shift_o, sync_clr_n_o, busy, done;
    logic [N*DW-1:0] lane_data;

    operand_feeder #(
        .DATA_WIDTH   (DW),
        .N            (N),
        .FLUSH_CYCLES (FL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .hold         (hold),
        .lane_data    (lane_data),
        .shift_o      (shift_o),
        .sync_clr_n_o (sync_clr_n_o),
        .busy         (busy),
        .done         (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: which phase the tile is in, elements loaded, shifts issued.
    lane_t src [NE];
    bit    m_loading, m_clr, m_win, m_done;
    int    m_loaded, m_shifts;
    int    obs_shifts, obs_done, obs_clr;

    task automatic model_reset();
        m_loading = 0; m_clr = 0; m_win = 0; m_done = 0;
        m_loaded  = 0; m_shifts = 0;
    endtask

    task automatic step();
        logic [N*DW-1:0] exp_lane;
        bit              exp_busy;
        @(negedge clk);
        exp_lane = '0;
        if (m_win && m_shifts < N) begin
            for (int r = 0; r < N; r++) exp_lane[r*DW +: DW] = src[r*N + m_shifts];
        end
        exp_busy = m_loading || m_clr || m_win || m_done;
        check_eq("in_ready",   64'(in_ready),     64'(m_loading));
        check_eq("busy",       64'(busy),         64'(exp_busy));
        check_eq("sync_clr_n", 64'(sync_clr_n_o), 64'(!m_clr));
        check_eq("shift_o",    64'(shift_o),      64'(m_win && !hold));
        check_eq("lane_data",  64'(lane_data),    64'(exp_lane));
        check_eq("done",       64'(done),         64'(m_done));
        if (shift_o)       obs_shifts++;
        if (done)          obs_done++;
        if (!sync_clr_n_o) obs_clr++;
        if (m_done) begin
            m_done = 0;
        end else if (m_win) begin
            if (!hold) begin
                m_shifts++;
                if (m_shifts == N + FL) begin
                    m_win  = 0;
                    m_done = 1;
                end
            end
        end else if (m_clr) begin
            m_clr = 0; m_win = 1; m_shifts = 0;
        end else if (m_loading) begin
            if (in_valid) begin
                m_loaded++;
                if (m_loaded == NE) begin
                    m_loading = 0;
                    m_clr     = 1;
                end
            end
        end else if (start) begin
            m_loading = 1;
            m_loaded  = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // hold_mode: 0 none, 1 three cycles at column 2, 2 random.
    task automatic run_tile(input int valid_pct, input int hold_mode,
                            input bit start_in_stream, input bit abort,
                            output bit aborted);
        int cyc = 0, hold_used = 0, holds_win = 0;
        int t_last_acc = -1, t_done = -1, od;
        bit finished = 0, was_done;
        aborted    = 0;
        obs_shifts = 0; obs_done = 0; obs_clr = 0;
        start = 1; in_valid = 0; hold = 0;
        step();
        start = 0;
        while (!finished && cyc < 400) begin
            in_valid = ($urandom_range(99) < valid_pct);
            in_data  = m_loading ? src[m_loaded] : DW'($urandom);
            case (hold_mode)
                1:       hold = m_win && m_shifts == 2 && hold_used < 3;
                2:       hold = ($urandom_range(3) == 0);
                default: hold = 0;
            endcase
            if (hold_mode == 1 && hold) hold_used++;
            start = start_in_stream && m_win;
            if (abort && m_win && m_shifts == N + 2) begin
                aborted = 1;
                break;
            end
            if (m_loading && in_valid && m_loaded == NE - 1) t_last_acc = cyc;
            if (m_win && hold) holds_win++;
            was_done = m_done;
            od       = obs_done;
            step();
            if (od == 0 && obs_done == 1) t_done = cyc;
            cyc++;
            if (was_done) finished = 1;
        end
        start = 0; in_valid = 0; hold = 0;
        if (!aborted) begin
            check_eq("tile_timeout", 64'(finished), 64'(1));
            check_eq("shift_count", 64'(obs_shifts), 64'(N + FL));
            check_eq("done_count",  64'(obs_done),   64'(1));
            check_eq("clr_count",   64'(obs_clr),    64'(1));
            check_eq("done_latency", 64'(t_done - t_last_acc), 64'(1 + N + FL + 1 + holds_win));
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NE; i++) src[i] = lane_t'($urandom);
    endtask

    bit ab;

    initial begin
        reset_n = 0; start = 0; in_valid = 0; hold = 0; in_data = '0;
        model_reset();
        for (int i = 0; i < NE; i++) src[i] = '0;
        repeat (2) step();
        reset_n = 1;

        // Stray valids while idle must not be acknowledged.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'($urandom_range(1));
            in_data  = DW'($urandom);
            step();
        end
        in_valid = 0;

        for (int i = 0; i < NE; i++) src[i] = lane_t'(i + 1);
        run_tile(100, 0, 0, 0, ab);
        run_tile(100, 1, 0, 0, ab);

        fill_random();
        run_tile(50, 0, 0, 0, ab);
        fill_random();
        run_tile(50, 2, 1, 0, ab);

        fill_random();
        run_tile(100, 0, 0, 1, ab);
        check_eq("abort_reached", 64'(ab), 64'(1));
        reset_n = 0;
        #1;
        check_eq("rst_in_ready",  64'(in_ready),     64'(0));
        check_eq("rst_shift_o",   64'(shift_o),      64'(0));
        check_eq("rst_sync_clr",  64'(sync_clr_n_o), 64'(1));
        check_eq("rst_lane_data", 64'(lane_data),    64'(0));
        check_eq("rst_busy",      64'(busy),         64'(0));
        check_eq("rst_done",      64'(done),         64'(0));
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1;
        step();

        fill_random();
        run_tile(70, 0, 0, 0, ab);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_feeder.md
# operand_feeder

Upstream stage of the systolic matrix-multiplier input path. It collects one N×N operand tile from a valid/ready element stream into an internal buffer. It then streams the tile column by column as N parallel lanes into the per-lane skew shift registers, followed by zero-padding to drain them. It drives the shift enable and the synchronous clear for those shift registers and signals completion with a one-cycle done pulse.

## Interface
- DATA_WIDTH, 8, width of one matrix element
- N, 4, tile dimension and lane count
- FLUSH_CYCLES, 2*N-1, zero-padding shifts issued after the last column
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a tile; ignored unless IDLE
- in_valid  in  1  element valid
- in_ready  out  1  element accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH  element, row-major order: index r*N+c = A[r][c]
- hold  in  1  downstream stall; freezes streaming
- lane_data  out  N*DATA_WIDTH  lane r at bits [r*DATA_WIDTH +: DATA_WIDTH]
- shift_o  out  1  shift enable to the skew registers
- sync_clr_n_o  out  1  synchronous clear to the skew registers, active-low
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on tile completion

## Operation
- States: IDLE, LOAD, CLEAR, STREAM, FLUSH, DONE.
- IDLE: start=1 → LOAD, element index cleared.
- LOAD: in_ready=1. Each accepted element is written to buffer[idx] and idx increments. Acceptance of element N*N-1 → CLEAR.
- CLEAR: exactly one cycle with sync_clr_n_o=0 → STREAM, column counter k=0.
- STREAM: lane r = buffer[r*N+k]. Each cycle with shift_o=1 increments k. The shift with k=N-1 → FLUSH, flush counter 0.
- FLUSH: lane_data all zeros. Each shift increments the counter. The shift with counter=FLUSH_CYCLES-1 → DONE.
- DONE: done=1 for one cycle → IDLE.
- shift_o = (state==STREAM || state==FLUSH) && !hold. It is combinational from the state register and hold.
- While hold=1, k, the flush counter and lane_data are frozen, and no state transition occurs.
- lane_data is registered. It holds its last value in IDLE, LOAD, CLEAR and DONE.
- Buffer contents persist after DONE. A new tile overwrites them only during LOAD.
- Counter widths: idx is $clog2(N*N+1), k is $clog2(N+1), flush counter is $clog2(FLUSH_CYCLES+1). No wrap-around is ever reached.

## Timing
- Reset values: in_ready=0, shift_o=0, sync_clr_n_o=1, lane_data=0, busy=0, done=0; state=IDLE; all counters 0.
- Reset asserted mid-operation aborts immediately to IDLE. A partially loaded tile is discarded and the buffer is not cleared.
- start → in_ready high on the next cycle.
- Last element accepted → CLEAR on the next cycle → first column on lane_data with shift_o on the following cycle.
- With no hold, STREAM lasts N cycles and FLUSH lasts FLUSH_CYCLES cycles.
- Total from last accept to done: 1+N+FLUSH_CYCLES+1 cycles.
- start while busy is ignored. in_valid outside LOAD is ignored and not acknowledged.
- hold during LOAD or CLEAR has no effect.
- hold asserted on the same cycle as the final STREAM shift suppresses that shift, so the transition waits.

## Structure
- Shared package matmul_pkg holds:
  - the feeder_state_e enum (the six states);
  - a lane_t typedef helper for a DATA_WIDTH element.
- The tile storage is a natural sub-module, feeder_tile_buffer: N*N×DATA_WIDTH with one write port and N parallel column-read ports indexed by k. The FSM and counters stay in operand_feeder.

## Test plan
- Reset then idle with N=4: all outputs hold their reset values. Pulsing in_valid without start gives in_ready=0 and no acceptance.
- Load elements 1..16 back-to-back with no hold: one sync_clr_n_o low pulse, then lane_data = {13,9,5,1} (lane3..lane0), {14,10,6,2}, {15,11,7,3}, {16,12,8,4}, then 7 zero cycles with shift_o=1, then done pulses once.
- Same tile with hold=1 for 3 cycles at k=2: shift_o=0 and lane_data stays {15,11,7,3} for exactly those 3 cycles. The total shift count is still 4+7, and done is delayed by 3 cycles.
- in_valid toggling 50% during LOAD: exactly 16 elements accepted. Element order is preserved in the output columns.
- start asserted during STREAM: no effect. A second start after done loads a new tile, and the new values appear on lane_data.
- reset_n low during the FLUSH of tile 1: the block returns to IDLE with all outputs at reset values. The next full tile streams correctly.
